// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_if
// Brief    : Bundle between the fetch-side predictor, hazard unit, datapath
//            E stage and the branch resolve unit. The master side drives the
//            pipeline inputs; the slave side (the resolve unit) drives the
//            prediction, redirect and predictor-update outputs.
// Revision : 1.0  initial release
// ============================================================================
interface branch_resolve_if #(
    parameter int PHT_INDEX_BITS = 7,
    parameter int BHT_INDEX_BITS = 3
);
    // Fetch-side prediction metadata
    logic                      predict_takeF;
    logic [BHT_INDEX_BITS-1:0] bht_indexF;
    logic [PHT_INDEX_BITS-1:0] pht_indexF;
    // Hazard unit controls
    logic                      stallD;
    logic                      stallE;
    logic                      stallM;
    logic                      flushD;
    logic                      flushE;
    logic                      flushM;
    // Datapath E-stage resolution
    logic                      branchE;
    logic                      actual_takenE;
    logic [31:0]               branch_targetE;
    logic [31:0]               fallthroughE;
    // Outputs of the resolve unit
    logic                      predict_takeD;
    logic                      mispredictE;
    logic [31:0]               redirect_pcE;
    logic                      branchM;
    logic [BHT_INDEX_BITS-1:0] BHT_indexM;
    logic [PHT_INDEX_BITS-1:0] PHT_indexM;
    logic                      takenM;
    logic [31:0]               branch_cnt;
    logic [31:0]               mispredict_cnt;

    modport master (
        output predict_takeF, bht_indexF, pht_indexF,
        output stallD, stallE, stallM, flushD, flushE, flushM,
        output branchE, actual_takenE, branch_targetE, fallthroughE,
        input  predict_takeD, mispredictE, redirect_pcE,
        input  branchM, BHT_indexM, PHT_indexM, takenM,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  predict_takeF, bht_indexF, pht_indexF,
        input  stallD, stallE, stallM, flushD, flushE, flushM,
        input  branchE, actual_takenE, branch_targetE, fallthroughE,
        output predict_takeD, mispredictE, redirect_pcE,
        output branchM, BHT_indexM, PHT_indexM, takenM,
        output branch_cnt, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Carries predictor metadata through D/E/M, resolves direction in
//            E (single-cycle mispredict + redirect PC) and drives the local
//            predictor update port from M.
//            Optional macro BRU_PERF_CNT_EN adds saturating branch and
//            mispredict counters; otherwise the counter outputs read 0.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int PHT_INDEX_BITS = 7,
    parameter int BHT_INDEX_BITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bru
);

    typedef struct packed {
        logic                      valid;
        logic                      pred;
        logic [BHT_INDEX_BITS-1:0] bht;
        logic [PHT_INDEX_BITS-1:0] pht;
    } meta_t;

    typedef struct packed {
        meta_t meta;
        logic  is_branch;
        logic  taken;
    } mstage_t;

    meta_t   d_q, d_d;
    meta_t   e_q, e_d;
    mstage_t m_q, m_d;

    logic    w_mispredictE;
    logic    w_branchM;

    // D stage next state: fetch always presents a valid instruction
    always_comb begin
        d_d = d_q;
        if (bru.flushD) begin
            d_d = '0;
        end else if (!bru.stallD) begin
            d_d.valid = 1'b1;
            d_d.pred  = bru.predict_takeF;
            d_d.bht   = bru.bht_indexF;
            d_d.pht   = bru.pht_indexF;
        end
    end

    // E stage next state: bubble when D is held so nothing is duplicated
    always_comb begin
        e_d = e_q;
        if (bru.flushE) begin
            e_d = '0;
        end else if (!bru.stallE) begin
            e_d = bru.stallD ? '0 : d_q;
        end
    end

    // M stage next state: also latches the resolved branch/outcome from E
    always_comb begin
        m_d = m_q;
        if (bru.flushM) begin
            m_d = '0;
        end else if (!bru.stallM) begin
            if (bru.stallE || !e_q.valid) begin
                m_d = '0;
            end else begin
                m_d.meta      = e_q;
                m_d.is_branch = bru.branchE;
                m_d.taken     = bru.actual_takenE;
            end
        end
    end

    // Stage registers; reset discards all in-flight metadata
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            e_q <= '0;
            m_q <= '0;
        end else begin
            d_q <= d_d;
            e_q <= e_d;
            m_q <= m_d;
        end
    end

    // Gating on !stallE makes the mispredict fire only on the advancing cycle
    assign w_mispredictE     = e_q.valid & bru.branchE & ~bru.stallE
                             & (e_q.pred ^ bru.actual_takenE);
    assign bru.mispredictE   = w_mispredictE;
    assign bru.redirect_pcE  = w_mispredictE
                             ? (bru.actual_takenE ? bru.branch_targetE : bru.fallthroughE)
                             : 32'h0;
    assign bru.predict_takeD = d_q.valid & d_q.pred;

    // Gating on !stallM yields one update pulse however long M is held
    assign w_branchM         = m_q.meta.valid & m_q.is_branch & ~bru.stallM;
    assign bru.branchM       = w_branchM;
    assign bru.BHT_indexM    = m_q.meta.valid ? m_q.meta.bht : '0;
    assign bru.PHT_indexM    = m_q.meta.valid ? m_q.meta.pht : '0;
    assign bru.takenM        = m_q.meta.valid & m_q.taken;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= 32'h0;
            mispredict_cnt_q <= 32'h0;
        end else begin
            if (w_branchM && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (w_mispredictE && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign bru.branch_cnt     = branch_cnt_q;
    assign bru.mispredict_cnt = mispredict_cnt_q;
`else
    assign bru.branch_cnt     = 32'h0;
    assign bru.mispredict_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
